x2050_ilc_hist: RTL and testbench

X2050_ILC_HIST -- requirements
Module: x2050_ilc_hist

---
 rtl/x2050_ilc_hist_if.sv | 33 +++
 rtl/x2050_ilc_hist.sv | 107 ++++++++++
 tb/tb_x2050_ilc_hist.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/x2050_ilc_hist_if.sv
// Signal bundle for the ILC history block: ROS controls in, ILC and history FIFO state out.
interface x2050_ilc_hist_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic            i_ros_advance;
  logic [4:0]      i_tr;
  logic [31:0]     i_t_reg;
  logic            i_ex_target;
  logic            i_int_take;
  logic            i_int_ilc0;
  logic            i_hist_rd;
  logic            i_hist_clr;
  logic [1:0]      o_ilc;
  logic [1:0]      o_old_ilc;
  logic [1:0]      o_hist_data;
  logic            o_hist_valid;
  logic [CntW-1:0] o_hist_count;
  logic            o_hist_ovf;

  modport master (
    output i_ros_advance, i_tr, i_t_reg, i_ex_target, i_int_take, i_int_ilc0,
    output i_hist_rd, i_hist_clr,
    input  o_ilc, o_old_ilc, o_hist_data, o_hist_valid, o_hist_count, o_hist_ovf
  );

  modport slave (
    input  i_ros_advance, i_tr, i_t_reg, i_ex_target, i_int_take, i_int_ilc0,
    input  i_hist_rd, i_hist_clr,
    output o_ilc, o_old_ilc, o_hist_data, o_hist_valid, o_hist_count, o_hist_ovf
  );
endinterface

// File: rtl/x2050_ilc_hist.sv
// Instruction-length-code tracker: captures ILC from the opcode class, keeps the old-PSW ILC
// across interrupt swaps, and logs captured ILCs in a lossy circular history FIFO.
module x2050_ilc_hist #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [4:0]  CAPTURE_TR  = 5'd25,
  parameter bit          EX_SUPPRESS = 1'b1
) (
  input logic               i_clk,
  input logic               i_reset_n,
  x2050_ilc_hist_if.slave   bus
);
  localparam int unsigned     PtrW = $clog2(DEPTH);
  localparam int unsigned     CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [1:0]      ilc_q, ilc_d;
  logic [1:0]      old_ilc_q, old_ilc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      mem_q [DEPTH];

  logic       b0, b1;
  logic [1:0] next_ilc;
  logic       capture, swap, push, pop, full, drop;
  logic       unused_t_reg;

  assign b0       = bus.i_t_reg[31];
  assign b1       = bus.i_t_reg[30];
  assign next_ilc = {b0 | b1, ~(b0 ^ b1)};
  assign unused_t_reg = ^bus.i_t_reg[29:0];

  assign capture = bus.i_ros_advance & (bus.i_tr == CAPTURE_TR)
                 & ~(EX_SUPPRESS & bus.i_ex_target);
  assign swap    = bus.i_ros_advance & bus.i_int_take;
  assign full    = (count_q == Full);
  assign push    = capture & ~bus.i_hist_clr;
  assign pop     = bus.i_hist_rd & (count_q != '0) & ~bus.i_hist_clr;
  // A push into a full FIFO without a pop evicts the oldest entry.
  assign drop    = push & full & ~pop;

  always_comb begin
    ilc_d     = capture ? next_ilc : ilc_q;
    old_ilc_d = old_ilc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    // Swap records the pre-edge ILC, so a same-cycle capture is not seen here.
    if (swap) begin
      old_ilc_d = bus.i_int_ilc0 ? 2'b00 : ilc_q;
    end
    if (bus.i_hist_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop || drop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop && !full) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ilc_q     <= 2'b00;
      old_ilc_q <= 2'b00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ilc_q     <= ilc_d;
      old_ilc_q <= old_ilc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= next_ilc;
    end
  end

  assign bus.o_ilc        = ilc_q;
  assign bus.o_old_ilc    = old_ilc_q;
  assign bus.o_hist_valid = (count_q != '0);
  assign bus.o_hist_data  = (count_q != '0) ? mem_q[rd_ptr_q] : 2'b00;
  assign bus.o_hist_count = count_q;
  assign bus.o_hist_ovf   = ovf_q;
endmodule

// File: tb/tb_x2050_ilc_hist.sv
// Randomised and directed bench for x2050_ilc_hist against a queue-based reference model.
module tb_x2050_ilc_hist;
  localparam int unsigned DEPTH = 4;

  logic i_clk;
  logic i_reset_n;
  int   checks = 0;
  int   errors = 0;

  x2050_ilc_hist_if #(.DEPTH(DEPTH)) bus ();

  x2050_ilc_hist #(
    .DEPTH      (DEPTH),
    .CAPTURE_TR (5'd25),
    .EX_SUPPRESS(1'b1)
  ) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .bus      (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model state
  logic [1:0] m_q[$];
  logic [1:0] m_ilc;
  logic [1:0] m_old;
  logic       m_ovf;
  logic [1:0] lut [4] = '{2'b01, 2'b10, 2'b10, 2'b11};

  task automatic model_reset();
    m_q.delete();
    m_ilc = 2'b00;
    m_old = 2'b00;
    m_ovf = 1'b0;
  endtask

  task automatic drive(input logic ros, input logic [4:0] tr, input logic [1:0] op,
                       input logic ex, input logic take, input logic ilc0,
                       input logic rd, input logic clr);
    bus.i_ros_advance = ros;
    bus.i_tr          = tr;
    bus.i_t_reg       = {op, 30'($urandom())};
    bus.i_ex_target   = ex;
    bus.i_int_take    = take;
    bus.i_int_ilc0    = ilc0;
    bus.i_hist_rd     = rd;
    bus.i_hist_clr    = clr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance the model from the current inputs, then clock the DUT and settle.
  task automatic step();
    logic       cap;
    logic [1:0] ni;
    cap = bus.i_ros_advance && (bus.i_tr == 5'd25) && !bus.i_ex_target;
    ni  = lut[bus.i_t_reg[31:30]];
    if (bus.i_ros_advance && bus.i_int_take) m_old = bus.i_int_ilc0 ? 2'b00 : m_ilc;
    if (cap) m_ilc = ni;
    if (bus.i_hist_clr) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (bus.i_hist_rd && m_q.size() > 0) void'(m_q.pop_front());
      if (cap) begin
        if (m_q.size() == DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
        m_q.push_back(ni);
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    idle();
    model_reset();
    #12;
    checks += 6;
    if (bus.o_ilc !== 2'b00) begin errors++; $display("FAIL rst_ilc got %b want 00", bus.o_ilc); end
    if (bus.o_old_ilc !== 2'b00) begin errors++; $display("FAIL rst_old got %b want 00", bus.o_old_ilc); end
    if (bus.o_hist_count !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", bus.o_hist_count); end
    if (bus.o_hist_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.o_hist_valid); end
    if (bus.o_hist_data !== 2'b00) begin errors++; $display("FAIL rst_data got %b want 00", bus.o_hist_data); end
    if (bus.o_hist_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", bus.o_hist_ovf); end
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [1:0] exp_ilc [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd25, 2'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checks++;
      if (bus.o_ilc !== exp_ilc[i]) begin
        errors++;
        $display("FAIL decode_%0d got %b want %b", i, bus.o_ilc, exp_ilc[i]);
      end
    end
    idle();
    checks++;
    if (bus.o_hist_count !== 3'd4) begin errors++; $display("FAIL decode_cnt got %0d want 4", bus.o_hist_count); end
  endtask

  task automatic test_no_capture();
    drive(1'b1, 5'd24, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd25, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd25, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    checks += 3;
    if (bus.o_ilc !== 2'b11) begin errors++; $display("FAIL nocap_ilc got %b want 11", bus.o_ilc); end
    if (bus.o_hist_count !== 3'd4) begin errors++; $display("FAIL nocap_cnt got %0d want 4", bus.o_hist_count); end
    if (bus.o_old_ilc !== 2'b00) begin errors++; $display("FAIL nocap_old got %b want 00", bus.o_old_ilc); end
  endtask

  task automatic test_overflow();
    logic [1:0] ops [5] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b01};
    logic [1:0] pops [4] = '{2'b10, 2'b11, 2'b01, 2'b10};
    drive(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd25, ops[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    idle();
    checks += 2;
    if (bus.o_hist_count !== 3'd4) begin errors++; $display("FAIL ovf_cnt got %0d want 4", bus.o_hist_count); end
    if (bus.o_hist_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.o_hist_ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.o_hist_data !== pops[i]) begin
        errors++;
        $display("FAIL ovf_pop_%0d got %b want %b", i, bus.o_hist_data, pops[i]);
      end
      drive(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    step();
    idle();
    checks += 3;
    if (bus.o_hist_valid !== 1'b0) begin errors++; $display("FAIL empty_valid got %b want 0", bus.o_hist_valid); end
    if (bus.o_hist_data !== 2'b00) begin errors++; $display("FAIL empty_data got %b want 00", bus.o_hist_data); end
    if (bus.o_hist_count !== 3'd0) begin errors++; $display("FAIL empty_pop_cnt got %0d want 0", bus.o_hist_count); end
  endtask

  task automatic test_push_pop_full();
    logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
    drive(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd25, ops[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 5'd25, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    checks += 3;
    if (bus.o_hist_count !== 3'd4) begin errors++; $display("FAIL pp_cnt got %0d want 4", bus.o_hist_count); end
    if (bus.o_hist_ovf !== 1'b0) begin errors++; $display("FAIL pp_ovf got %b want 0", bus.o_hist_ovf); end
    if (bus.o_hist_data !== 2'b10) begin errors++; $display("FAIL pp_head got %b want 10", bus.o_hist_data); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    idle();
    checks++;
    if (bus.o_hist_data !== 2'b11) begin errors++; $display("FAIL pp_tail got %b want 11", bus.o_hist_data); end
  endtask

  task automatic test_swap();
    drive(1'b1, 5'd25, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd25, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checks += 2;
    if (bus.o_old_ilc !== 2'b10) begin errors++; $display("FAIL swap_old got %b want 10", bus.o_old_ilc); end
    if (bus.o_ilc !== 2'b11) begin errors++; $display("FAIL swap_ilc got %b want 11", bus.o_ilc); end
    drive(1'b1, 5'd25, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd25, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    checks += 2;
    if (bus.o_old_ilc !== 2'b00) begin errors++; $display("FAIL swap0_old got %b want 00", bus.o_old_ilc); end
    if (bus.o_ilc !== 2'b11) begin errors++; $display("FAIL swap0_ilc got %b want 11", bus.o_ilc); end
  endtask

  task automatic test_async_reset_and_clr();
    drive(1'b1, 5'd25, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd25, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    i_reset_n = 1'b0;
    #1;
    checks += 4;
    if (bus.o_ilc !== 2'b00) begin errors++; $display("FAIL arst_ilc got %b want 00", bus.o_ilc); end
    if (bus.o_old_ilc !== 2'b00) begin errors++; $display("FAIL arst_old got %b want 00", bus.o_old_ilc); end
    if (bus.o_hist_count !== 3'd0) begin errors++; $display("FAIL arst_cnt got %0d want 0", bus.o_hist_count); end
    if (bus.o_hist_data !== 2'b00) begin errors++; $display("FAIL arst_data got %b want 00", bus.o_hist_data); end
    idle();
    model_reset();
    #1;
    i_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd25, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 5'd25, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    idle();
    checks += 3;
    if (bus.o_hist_count !== 3'd0) begin errors++; $display("FAIL clr_cnt got %0d want 0", bus.o_hist_count); end
    if (bus.o_hist_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", bus.o_hist_ovf); end
    if (bus.o_ilc !== 2'b10) begin errors++; $display("FAIL clr_ilc got %b want 10", bus.o_ilc); end
  endtask

  task automatic test_random();
    logic [1:0] exp_data;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 1) ? 5'd25 : 5'($urandom()),
            2'($urandom()),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 29) == 0));
      step();
      exp_data = (m_q.size() > 0) ? m_q[0] : 2'b00;
      checks += 6;
      if (bus.o_ilc !== m_ilc) begin
        errors++; $display("FAIL rnd_ilc cyc %0d got %b want %b", i, bus.o_ilc, m_ilc);
      end
      if (bus.o_old_ilc !== m_old) begin
        errors++; $display("FAIL rnd_old cyc %0d got %b want %b", i, bus.o_old_ilc, m_old);
      end
      if (bus.o_hist_count !== 3'(m_q.size())) begin
        errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, bus.o_hist_count, m_q.size());
      end
      if (bus.o_hist_valid !== (m_q.size() > 0)) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %b", i, bus.o_hist_valid);
      end
      if (bus.o_hist_data !== exp_data) begin
        errors++; $display("FAIL rnd_data cyc %0d got %b want %b", i, bus.o_hist_data, exp_data);
      end
      if (bus.o_hist_ovf !== m_ovf) begin
        errors++; $display("FAIL rnd_ovf cyc %0d got %b want %b", i, bus.o_hist_ovf, m_ovf);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_no_capture();
    test_overflow();
    test_push_pop_full();
    test_swap();
    test_async_reset_and_clr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
